depth_point_scheduler: RTL

//  Buffers laser-line pixel hits from the stripe detector and feeds them one at a time into
//  the depth reconstruction datapath. Holds px_x/px_y stable while the datapath runs, waits
//  for its divider-done flag, captures the world point and hands it to the point-memory writer.

---
 rtl/depth_point_scheduler.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/depth_point_scheduler.sv
// Pixel FIFO plus sequencer that feeds one stripe hit at a time to the depth datapath and forwards world points.
// Optional watchdog in WAIT/HOLD enabled by defining DEPTH_SCHED_TIMEOUT_EN.
module depth_point_scheduler #(
  parameter int FIFO_DEPTH    = 16,
  parameter int FIFO_AW       = 4,
  parameter int CAPTURE_DELAY = 2,
  parameter int TIMEOUT_CYC   = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start_i,
  input  logic        pix_valid_i,
  output logic        pix_ready_o,
  input  logic [11:0] pix_x_i,
  input  logic [11:0] pix_y_i,
  output logic [11:0] rc_px_x_o,
  output logic [11:0] rc_px_y_o,
  input  logic        rc_done_i,
  input  logic [12:0] rc_wpt1_i,
  input  logic [12:0] rc_wpt2_i,
  input  logic [12:0] rc_wpt3_i,
  output logic        pt_valid_o,
  input  logic        pt_ready_i,
  output logic [12:0] pt_x_o,
  output logic [12:0] pt_y_o,
  output logic [12:0] pt_z_o,
  output logic [15:0] pt_count_o,
  output logic        busy_o,
  output logic        timeout_err_o
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_HOLD, S_OUT} state_t;

  localparam int CD_W = (CAPTURE_DELAY > 1) ? $clog2(CAPTURE_DELAY) : 1;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(FIFO_DEPTH);

  state_t              state_q;
  logic [23:0]         fifo_mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]    count_q, count_d;
  logic                pix_ready_q, pt_valid_q, done_prev_q, cache_valid_q;
  logic [11:0]         rc_px_x_q, rc_px_y_q, cache_x_q, cache_y_q;
  logic [12:0]         pt_x_q, pt_y_q, pt_z_q, cache_p1_q, cache_p2_q, cache_p3_q;
  logic [15:0]         pt_count_q;
  logic [CD_W-1:0]     hold_cnt_q;
  logic                push, pop, capture, cache_hit;
  logic [23:0]         head;

  always_comb begin
    head      = fifo_mem_q[rd_ptr_q];
    push      = pix_valid_i && pix_ready_q && !frame_start_i;
    pop       = (state_q == S_IDLE) && (count_q != '0) && !frame_start_i;
    capture   = (state_q == S_HOLD) && (hold_cnt_q == CD_W'(CAPTURE_DELAY - 1));
    cache_hit = cache_valid_q && (head == {cache_x_q, cache_y_q});
    count_d   = count_q;
    if (frame_start_i)     count_d = '0;
    else if (push && !pop) count_d = count_q + (FIFO_AW+1)'(1);
    else if (pop && !push) count_d = count_q - (FIFO_AW+1)'(1);
  end

  // Storage has no reset: pointers and occupancy define what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {pix_x_i, pix_y_i};
  end

`ifdef DEPTH_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;
  logic [WD_W-1:0] wd_cnt_q;
  logic            timeout_err_q;
`endif

  always_ff @(posedge clk) begin
    done_prev_q <= rc_done_i;
    if (!rst_n) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      pix_ready_q   <= 1'b0;
      pt_valid_q    <= 1'b0;
      done_prev_q   <= 1'b0;
      cache_valid_q <= 1'b0;
      rc_px_x_q     <= '0;
      rc_px_y_q     <= '0;
      cache_x_q     <= '0;
      cache_y_q     <= '0;
      pt_x_q        <= '0;
      pt_y_q        <= '0;
      pt_z_q        <= '0;
      cache_p1_q    <= '0;
      cache_p2_q    <= '0;
      cache_p3_q    <= '0;
      pt_count_q    <= '0;
      hold_cnt_q    <= '0;
`ifdef DEPTH_SCHED_TIMEOUT_EN
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else if (frame_start_i) begin
      // Abort everything; rc_px_x/y deliberately keep their last value.
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      pix_ready_q   <= 1'b1;
      pt_valid_q    <= 1'b0;
      pt_count_q    <= '0;
      cache_valid_q <= 1'b0;
`ifdef DEPTH_SCHED_TIMEOUT_EN
      timeout_err_q <= 1'b0;
`endif
    end else begin
      count_q     <= count_d;
      pix_ready_q <= (count_d != FULL_CNT);
      if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);

      case (state_q)
        S_IDLE: if (pop) begin
          rc_px_x_q <= head[23:12];
          rc_px_y_q <= head[11:0];
          // Same pixel as the cached one: the divider would not restart, so reuse the point.
          if (cache_hit) begin
            pt_x_q     <= cache_p1_q;
            pt_y_q     <= cache_p2_q;
            pt_z_q     <= cache_p3_q;
            pt_valid_q <= 1'b1;
            state_q    <= S_OUT;
          end else begin
            state_q    <= S_LOAD;
          end
        end
        S_LOAD: begin
          state_q <= S_WAIT;
`ifdef DEPTH_SCHED_TIMEOUT_EN
          wd_cnt_q <= '0;
`endif
        end
        S_WAIT: if (rc_done_i && !done_prev_q) begin
          state_q    <= S_HOLD;
          hold_cnt_q <= '0;
        end
        S_HOLD: if (capture) begin
          pt_x_q        <= rc_wpt1_i;
          pt_y_q        <= rc_wpt2_i;
          pt_z_q        <= rc_wpt3_i;
          cache_x_q     <= rc_px_x_q;
          cache_y_q     <= rc_px_y_q;
          cache_p1_q    <= rc_wpt1_i;
          cache_p2_q    <= rc_wpt2_i;
          cache_p3_q    <= rc_wpt3_i;
          cache_valid_q <= 1'b1;
          pt_valid_q    <= 1'b1;
          state_q       <= S_OUT;
        end else begin
          hold_cnt_q <= hold_cnt_q + CD_W'(1);
        end
        S_OUT: if (pt_ready_i) begin
          pt_valid_q <= 1'b0;
          if (pt_count_q != 16'hFFFF) pt_count_q <= pt_count_q + 16'd1;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

`ifdef DEPTH_SCHED_TIMEOUT_EN
      // Watchdog overrides the case above when it expires.
      if ((state_q == S_WAIT || state_q == S_HOLD) && !capture) begin
        if (wd_cnt_q == WD_W'(TIMEOUT_CYC - 1)) begin
          state_q       <= S_IDLE;
          timeout_err_q <= 1'b1;
          cache_valid_q <= 1'b0;
        end else begin
          wd_cnt_q <= wd_cnt_q + WD_W'(1);
        end
      end
`endif
    end
  end

  assign pix_ready_o = pix_ready_q;
  assign rc_px_x_o   = rc_px_x_q;
  assign rc_px_y_o   = rc_px_y_q;
  assign pt_valid_o  = pt_valid_q;
  assign pt_x_o      = pt_x_q;
  assign pt_y_o      = pt_y_q;
  assign pt_z_o      = pt_z_q;
  assign pt_count_o  = pt_count_q;
  assign busy_o      = (count_q != '0) || (state_q != S_IDLE);
`ifdef DEPTH_SCHED_TIMEOUT_EN
  assign timeout_err_o = timeout_err_q;
`else
  // Always false; written against the parameter so it stays referenced without the watchdog.
  assign timeout_err_o = (TIMEOUT_CYC < 0);
`endif

endmodule
